rx_ctrl: RTL and testbench

Receive-side controller that sits between the UART receiver datapath and its consumer. It owns the receiver's runtime configuration (prescale, parity enable/type) and applies changes only while the line is idle. It captures each completed frame and its error flags into a small FIFO, presents them to the consumer over a valid/ready handshake, and keeps saturating error statistics and a sticky overflow flag.

---
 rtl/rx_ctrl_pkg.sv | 31 +++
 rtl/rx_ctrl_fifo.sv | 68 ++++++
 rtl/rx_ctrl.sv | 141 ++++++++++++++
 tb/tb_rx_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive-side controller (rx_ctrl).
// Entry/config structs, config FSM state enum, and the saturating counter step.
package rx_ctrl_pkg;

    localparam int PRESCALE_W = 6;
    localparam int CNT_W      = 8;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] err;
    } entry_t;

    typedef struct packed {
        logic [PRESCALE_W-1:0] prescale;
        logic                  par_en;
        logic                  par_typ;
    } cfg_t;

    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rx_ctrl_fifo.sv
// Synchronous FIFO for rx_ctrl: power-of-two DEPTH, registered valid/full,
// accepts a push while full when a pop happens in the same cycle.
module rx_ctrl_fifo
    import rx_ctrl_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  ENTRY_T din,
    input  logic   pop,
    output ENTRY_T dout,
    output logic   valid,
    output logic   full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    ENTRY_T          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            pop_ok;
    logic            push_ok;

    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            valid <= (count_nxt != '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/rx_ctrl.sv
// UART receive-side controller: idle-gated runtime config, frame FIFO, error stats.
// Build option RX_CTRL_DROP_ERR_EN: discard frames carrying any error flag.
module rx_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int                    DEPTH        = 4,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = 6'd16
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_cfg_wr,
    input  logic [PRESCALE_W-1:0] i_cfg_prescale,
    input  logic                  i_cfg_par_en,
    input  logic                  i_cfg_par_typ,
    output logic                  o_cfg_busy,
    output logic [PRESCALE_W-1:0] o_prescale,
    output logic                  o_par_en,
    output logic                  o_par_typ,
    input  logic                  i_rx_active,
    input  logic                  i_rx_done,
    input  logic [1:0]            i_rx_error,
    input  logic [7:0]            i_rx_data,
    output logic                  o_valid,
    output logic [7:0]            o_data,
    output logic [1:0]            o_error,
    input  logic                  i_ready,
    output logic                  o_overflow,
    output logic [CNT_W-1:0]      o_par_err_cnt,
    output logic [CNT_W-1:0]      o_stp_err_cnt,
    input  logic                  i_clr
);

    logic       done_q;
    logic       done_rise;
    logic       push_en;
    logic       pop;
    logic       fifo_full;
    entry_t     push_entry;
    entry_t     head;
    cfg_state_t state;
    cfg_t       shadow;
    cfg_t       req_cfg;
    logic       apply_ok;

    assign done_rise = i_rx_done & ~done_q;
    assign pop       = o_valid & i_ready;
    assign req_cfg   = '{prescale: i_cfg_prescale, par_en: i_cfg_par_en, par_typ: i_cfg_par_typ};

`ifdef RX_CTRL_DROP_ERR_EN
    assign push_en    = done_rise & ~(|i_rx_error);
    assign push_entry = '{data: i_rx_data, err: 2'b00};
    assign o_error    = 2'b00;
`else
    assign push_en    = done_rise;
    assign push_entry = '{data: i_rx_data, err: i_rx_error};
    assign o_error    = head.err;
`endif

    assign o_data = head.data;

    rx_ctrl_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_arst_n),
        .push  (push_en),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .valid (o_valid),
        .full  (fifo_full)
    );

    // Frame edge detect and error statistics; clear wins over same-cycle updates.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            done_q        <= 1'b0;
            o_overflow    <= 1'b0;
            o_par_err_cnt <= '0;
            o_stp_err_cnt <= '0;
        end else begin
            done_q <= i_rx_done;
            if (i_clr) begin
                o_overflow    <= 1'b0;
                o_par_err_cnt <= '0;
                o_stp_err_cnt <= '0;
            end else begin
                if (push_en && fifo_full && !pop) begin
                    o_overflow <= 1'b1;
                end
                o_par_err_cnt <= sat_inc(o_par_err_cnt, done_rise & i_rx_error[0]);
                o_stp_err_cnt <= sat_inc(o_stp_err_cnt, done_rise & i_rx_error[1]);
            end
        end
    end

    // Never retune the receiver mid-frame or on the cycle a frame completes.
    assign apply_ok = ~i_rx_active & ~done_rise;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= CFG_IDLE;
            shadow     <= '{prescale: PRESCALE_RST, par_en: 1'b0, par_typ: 1'b0};
            o_prescale <= PRESCALE_RST;
            o_par_en   <= 1'b0;
            o_par_typ  <= 1'b0;
            o_cfg_busy <= 1'b0;
        end else begin
            case (state)
                CFG_IDLE: begin
                    if (i_cfg_wr) begin
                        shadow     <= req_cfg;
                        state      <= CFG_PEND;
                        o_cfg_busy <= 1'b1;
                    end
                end
                CFG_PEND: begin
                    if (apply_ok) begin
                        o_prescale <= shadow.prescale;
                        o_par_en   <= shadow.par_en;
                        o_par_typ  <= shadow.par_typ;
                        if (i_cfg_wr) begin
                            shadow <= req_cfg;
                        end else begin
                            state      <= CFG_IDLE;
                            o_cfg_busy <= 1'b0;
                        end
                    end else if (i_cfg_wr) begin
                        shadow <= req_cfg;
                    end
                end
                default: begin
                    state      <= CFG_IDLE;
                    o_cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed testbench for rx_ctrl (DEPTH 4); honours RX_CTRL_DROP_ERR_EN when defined.
module tb_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_wr;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       cfg_busy;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       rx_active;
    logic       rx_done;
    logic [1:0] rx_error;
    logic [7:0] rx_data;
    logic       valid;
    logic [7:0] data;
    logic [1:0] error;
    logic       ready;
    logic       overflow;
    logic [7:0] par_cnt;
    logic [7:0] stp_cnt;
    logic       clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_ctrl #(.DEPTH(4), .PRESCALE_RST(6'd16)) dut (
        .i_clk          (clk),
        .i_arst_n       (rst_n),
        .i_cfg_wr       (cfg_wr),
        .i_cfg_prescale (cfg_prescale),
        .i_cfg_par_en   (cfg_par_en),
        .i_cfg_par_typ  (cfg_par_typ),
        .o_cfg_busy     (cfg_busy),
        .o_prescale     (prescale),
        .o_par_en       (par_en),
        .o_par_typ      (par_typ),
        .i_rx_active    (rx_active),
        .i_rx_done      (rx_done),
        .i_rx_error     (rx_error),
        .i_rx_data      (rx_data),
        .o_valid        (valid),
        .o_data         (data),
        .o_error        (error),
        .i_ready        (ready),
        .o_overflow     (overflow),
        .o_par_err_cnt  (par_cnt),
        .o_stp_err_cnt  (stp_cnt),
        .i_clr          (clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input logic [1:0] e);
        rx_data  = d;
        rx_error = e;
        rx_done  = 1'b1;
        tick();
        rx_done  = 1'b0;
        rx_error = 2'b00;
        tick();
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic write_cfg(input logic [5:0] p, input logic en, input logic typ);
        cfg_prescale = p;
        cfg_par_en   = en;
        cfg_par_typ  = typ;
        cfg_wr       = 1'b1;
        tick();
        cfg_wr       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_prescale = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        rx_active = 1'b0; rx_done = 1'b0; rx_error = '0; rx_data = '0; ready = 1'b0; clr = 1'b0;
        #2;
        check("rst_valid", valid, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_valid2", valid, 0);
        check("rst_data", data, 0);
        check("rst_error", error, 0);
        check("rst_ovf", overflow, 0);
        check("rst_par_cnt", par_cnt, 0);
        check("rst_stp_cnt", stp_cnt, 0);
        check("rst_prescale", prescale, 16);
        check("rst_par_en", par_en, 0);
        check("rst_par_typ", par_typ, 0);
        check("rst_busy", cfg_busy, 0);

        // Long done pulse yields a single entry.
        rx_data = 8'hA5; rx_done = 1'b1;
        tick();
        check("long_valid", valid, 1);
        check("long_data", data, 8'hA5);
        repeat (4) tick();
        rx_done = 1'b0;
        tick();
        pop_one();
        check("long_single", valid, 0);

        // Fill past depth with consumer stalled.
        for (int i = 1; i <= 5; i++) frame(8'(i), 2'b00);
        check("fill_ovf", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check("fill_valid", valid, 1);
            check("fill_data", data, 32'(i));
            pop_one();
        end
        check("fill_empty", valid, 0);
        do_clr();
        check("ovf_clr", overflow, 0);

        // Push and pop together while full.
        for (int i = 1; i <= 4; i++) frame(8'(i), 2'b00);
        rx_data = 8'h05; rx_done = 1'b1; ready = 1'b1;
        tick();
        ready = 1'b0; rx_done = 1'b0;
        tick();
        check("fullpp_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            check("fullpp_data", data, 32'(i));
            pop_one();
        end
        check("fullpp_empty", valid, 0);

        // Error frames.
        for (int i = 0; i < 5; i++) begin
            frame(8'h30 + 8'(i), (i < 3) ? 2'b01 : 2'b10);
`ifdef RX_CTRL_DROP_ERR_EN
            check("err_drop_valid", valid, 0);
`else
            check("err_valid", valid, 1);
            check("err_flags", error, (i < 3) ? 32'h1 : 32'h2);
            pop_one();
`endif
        end
        check("err_par_cnt", par_cnt, 3);
        check("err_stp_cnt", stp_cnt, 2);
        check("err_no_ovf", overflow, 0);

        // Config deferred while receiver active.
        rx_active = 1'b1;
        write_cfg(6'd8, 1'b0, 1'b0);
        check("cfg_busy", cfg_busy, 1);
        check("cfg_hold", prescale, 16);
        repeat (3) tick();
        check("cfg_hold2", prescale, 16);
        rx_active = 1'b0;
        tick();
        check("cfg_applied", prescale, 8);
        check("cfg_idle", cfg_busy, 0);

        // Last write wins.
        rx_active = 1'b1;
        write_cfg(6'd12, 1'b0, 1'b0);
        write_cfg(6'd10, 1'b1, 1'b1);
        check("cfg2_hold", prescale, 8);
        rx_active = 1'b0;
        tick();
        check("cfg2_prescale", prescale, 10);
        check("cfg2_par_en", par_en, 1);
        check("cfg2_par_typ", par_typ, 1);

        // Idle latency: written at edge k, live at k+1.
        write_cfg(6'd20, 1'b0, 1'b1);
        check("cfg3_busy", cfg_busy, 1);
        check("cfg3_old", prescale, 10);
        tick();
        check("cfg3_new", prescale, 20);
        check("cfg3_par_en", par_en, 0);

        // Counter saturation and clear.
        ready = 1'b1;
        for (int i = 0; i < 260; i++) frame(8'h55, 2'b01);
        ready = 1'b0;
        check("sat_par", par_cnt, 8'hFF);
        check("sat_stp", stp_cnt, 2);
        do_clr();
        check("clr_par", par_cnt, 0);
        check("clr_stp", stp_cnt, 0);

        // Reset mid-pending with an entry queued.
        frame(8'h77, 2'b00);
        rx_active = 1'b1;
        write_cfg(6'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_prescale", prescale, 16);
        rx_active = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_prescale", prescale, 16);
        check("post_rst_valid", valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
